// File: rtl/switch_input_port.sv
// switch_input_port
//   Samples the raw, asynchronous board switches. Each line passes through a
//   two-flop synchronizer. The synchronized vector is then debounced as a whole
//   into a stable value. A sticky change flag is raised whenever that stable
//   value updates. The CPU reads the value through a one-cycle read-strobe /
//   read-valid handshake.
//
// Parameters
//   WIDTH            number of switch lines
//   DEBOUNCE_CYCLES  consecutive identical synchronized samples needed to commit (>= 2)
//   CNT_W            debounce counter width (derived)
//
// Ports
//   clock     system clock, rising-edge active
//   reset     synchronous, active-low reset
//   switches  raw asynchronous switch levels
//   rd_en     CPU read strobe
//   rd_data   value returned by the read; meaningful when rd_valid=1, held otherwise
//   rd_valid  one-cycle read-response pulse, one cycle after rd_en
//   stable    current debounced switch value
//   changed   sticky flag; stable changed since the last read
module switch_input_port #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] stable,
  output logic             changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      stable   <= '0;
      changed  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      // Synchronizer stage
      sync1 <= switches;
      sync2 <= sync1;

      // Read stage: return the pre-edge stable value and clear the flag.
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= stable;
        changed <= 1'b0;
      end

      // Debounce stage: any bit change restarts the count for the whole vector.
      // The commit is written after the read clear so a same-edge set wins.
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else if (cand != stable) begin
        stable  <= cand;
        changed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_input_port.sv
// tb_switch_input_port
//   Self-checking bench for switch_input_port (default parameters).
//   Read responses are predicted when rd_en is driven (queued) and matched
//   against rd_data whenever rd_valid is observed.
module tb_switch_input_port;

  logic       clock;
  logic       reset;
  logic [3:0] switches;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic [3:0] stable;
  logic       changed;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  switch_input_port dut (
    .clock    (clock),
    .reset    (reset),
    .switches (switches),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .stable   (stable),
    .changed  (changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard consumer: every rd_valid pulse must match a queued prediction.
  always @(negedge clock) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: rd_valid=1 rd_data=%b with no read outstanding", rd_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (rd_data !== exp_v) begin
          errors++;
          $display("FAIL rd_data: got %b expected %b", rd_data, exp_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; switches = 4'b0000; rd_en = 1'b0;
    repeat (3) tick();
    checks++;
    if ({stable, changed, rd_valid, rd_data} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state: stable=%b changed=%b rd_valid=%b rd_data=%b expected all 0",
               stable, changed, rd_valid, rd_data);
    end
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (stable !== 4'b0000 || changed !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc%0d: stable=%b changed=%b rd_valid=%b expected 0000/0/0",
                 k, stable, changed, rd_valid);
      end
    end
  endtask

  task automatic test_glitch();
    switches = 4'b0101;
    repeat (10) tick();
    switches = 4'b0000;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (stable !== 4'b0000 || changed !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc%0d: stable=%b changed=%b expected 0000/0", k, stable, changed);
      end
    end
  endtask

  task automatic test_clean_change();
    switches = 4'b1010;  // first captured at edge 0
    for (int k = 0; k <= 18; k++) begin
      tick();
      checks++;
      if (k < 18) begin
        if (stable !== 4'b0000 || changed !== 1'b0) begin
          errors++;
          $display("FAIL clean_change_hold edge%0d: stable=%b changed=%b expected 0000/0", k, stable, changed);
        end
      end else begin
        if (stable !== 4'b1010 || changed !== 1'b1) begin
          errors++;
          $display("FAIL clean_change_commit edge%0d: stable=%b changed=%b expected 1010/1", k, stable, changed);
        end
      end
    end
  endtask

  task automatic test_read_after_commit();
    rd_en = 1'b1;
    exp_q.push_back(4'b1010);
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || changed !== 1'b0) begin
      errors++;
      $display("FAIL read_response: rd_valid=%b changed=%b expected 1/0", rd_valid, changed);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 4'b1010) begin
      errors++;
      $display("FAIL read_pulse_end: rd_valid=%b rd_data=%b expected 0/1010 held", rd_valid, rd_data);
    end
  endtask

  task automatic test_collision();
    switches = 4'b0011;
    for (int k = 0; k <= 17; k++) tick();
    checks++;
    if (stable !== 4'b1010 || changed !== 1'b0) begin
      errors++;
      $display("FAIL collision_precommit: stable=%b changed=%b expected 1010/0", stable, changed);
    end
    rd_en = 1'b1;               // sampled at commit edge 18
    exp_q.push_back(4'b1010);
    tick();
    rd_en = 1'b0;
    checks++;
    if (stable !== 4'b0011 || changed !== 1'b1 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL collision_commit: stable=%b changed=%b rd_valid=%b expected 0011/1/1",
               stable, changed, rd_valid);
    end
    rd_en = 1'b1;
    exp_q.push_back(4'b0011);
    tick();
    rd_en = 1'b0;
    checks++;
    if (changed !== 1'b0 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL collision_second_read: changed=%b rd_valid=%b expected 0/1", changed, rd_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(4'b0011);
      tick();
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back rd%0d: rd_valid=%b expected 1", k, rd_valid);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_end: rd_valid=%b expected 0", rd_valid);
    end
  endtask

  task automatic test_reset_mid_debounce();
    switches = 4'b1111;
    repeat (8) tick();
    reset = 1'b0;
    rd_en = 1'b1;  // reset must dominate the read strobe
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({stable, changed, rd_valid, rd_data} !== 10'b0) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: stable=%b changed=%b rd_valid=%b rd_data=%b expected all 0",
                 k, stable, changed, rd_valid, rd_data);
      end
    end
    reset = 1'b1;
    rd_en = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      tick();
      checks++;
      if (k < 18) begin
        if (stable !== 4'b0000 || changed !== 1'b0) begin
          errors++;
          $display("FAIL reset_recover_hold edge%0d: stable=%b changed=%b expected 0000/0", k, stable, changed);
        end
      end else begin
        if (stable !== 4'b1111 || changed !== 1'b1) begin
          errors++;
          $display("FAIL reset_recover_commit edge%0d: stable=%b changed=%b expected 1111/1", k, stable, changed);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    switches = 4'b0000;
    rd_en = 1'b0;
    test_reset();
    test_glitch();
    test_clean_change();
    test_read_after_commit();
    test_collision();
    test_back_to_back();
    test_reset_mid_debounce();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reads_outstanding: %0d responses missing, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
